// File: rtl/load_store_unit.sv
// Load/store unit: turns one execute-stage memory op into a
// req/gnt/rvalid bus access and returns the extended load result.
module load_store_unit #(
  localparam int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_c,
  input  logic            we_c,
  input  logic [2:0]      funct3_c,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            stall_o,
  output logic            done_o,
  output logic            err_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [3:0]      mem_be_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

  state_t            state;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic              illegal;
  logic              accept;
  logic [3:0]        be_n;
  logic [XLEN-1:0]   wd_n;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [XLEN-1:0]   ext;

  always_comb begin
    illegal = 1'b0;
    case (funct3_c)
      3'b000:  illegal = 1'b0;
      3'b001:  illegal = addr_i[0];
      3'b010:  illegal = |addr_i[1:0];
      3'b100:  illegal = we_c;
      3'b101:  illegal = we_c | addr_i[0];
      default: illegal = 1'b1;
    endcase
  end

  assign accept = (state == IDLE) && req_c && !illegal;

  always_comb begin
    be_n = 4'b1111;
    wd_n = '0;
    if (we_c) begin
      unique case (funct3_c[1:0])
        2'b10: begin
          be_n = 4'b1111;
          wd_n = wdata_i;
        end
        2'b01: begin
          be_n = addr_i[1] ? 4'b1100 : 4'b0011;
          wd_n = {2{wdata_i[15:0]}};
        end
        default: begin
          be_n = 4'b0001 << addr_i[1:0];
          wd_n = {4{wdata_i[7:0]}};
        end
      endcase
    end
  end

  // f3_q[2] marks the unsigned (BU/HU) variants
  always_comb begin
    byte_v = mem_rdata_i[{off_q, 3'b000} +: 8];
    half_v = off_q[1] ? mem_rdata_i[31:16]
                      : mem_rdata_i[15:0];
    unique case (f3_q[1:0])
      2'b00:   ext = {{24{byte_v[7] & ~f3_q[2]}}, byte_v};
      2'b01:   ext = {{16{half_v[15] & ~f3_q[2]}}, half_v};
      default: ext = mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      f3_q        <= '0;
      off_q       <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_be_o    <= '0;
      rdata_o     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state       <= REQ;
            we_q        <= we_c;
            f3_q        <= funct3_c;
            off_q       <= addr_i[1:0];
            mem_addr_o  <= {addr_i[31:2], 2'b00};
            mem_wdata_o <= wd_n;
            mem_be_o    <= be_n;
          end
        end
        REQ: begin
          if (mem_gnt_i) state <= we_q ? RESP : WAIT;
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            rdata_o <= ext;
            state   <= RESP;
          end
        end
        RESP: state <= IDLE;
      endcase
    end
  end

  assign mem_req_o = (state == REQ);
  assign mem_we_o  = (state == REQ) && we_q;
  assign done_o    = (state == RESP);
  assign err_o     = rst_n && (state == IDLE)
                     && req_c && illegal;
  assign stall_o   = rst_n && (accept
                     || state == REQ
                     || state == WAIT);

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: reactive bus model, directed cases
// and randomized ops checked against an arithmetic reference.
module tb_load_store_unit;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        req_c = 0;
  logic        we_c = 0;
  logic [2:0]  funct3_c = 0;
  logic [31:0] addr_i = 0;
  logic [31:0] wdata_i = 0;
  logic        stall_o, done_o, err_o;
  logic [31:0] rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i = 0;
  logic        mem_rvalid_i = 0;
  logic [31:0] mem_rdata_i = 0;

  int          n_run = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] m_rdata = 0;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .req_c(req_c), .we_c(we_c),
    .funct3_c(funct3_c), .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .done_o(done_o), .err_o(err_o),
    .rdata_o(rdata_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  // One complete op starting in an idle cycle; bus answers after
  // gd request cycles and rd wait cycles.
  task automatic do_op(input bit we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int gd, input int rd,
                       input logic [31:0] word,
                       output int t_done);
    int          size, off, lat, nreq, waitc, exp_lat;
    bit          ok, granted;
    logic [31:0] mask, val, exp_wd;
    logic [3:0]  exp_be;
    size = 1 << (int'(f3) % 4);
    off  = int'(a % 4);
    ok   = !(f3 inside {3'd3, 3'd6, 3'd7})
           && (a % size == 0) && !(we && f3 >= 3);
    mask = (size == 4) ? 32'hFFFF_FFFF
                       : (32'h1 << (8 * size)) - 32'h1;
    val  = (word >> (8 * off)) & mask;
    if (!we && f3 < 4 && size < 4 && val[8*size-1])
      val = val | ~mask;
    exp_be = 4'(((1 << size) - 1) << off);
    if (!we) begin
      exp_be = 4'hF;
      exp_wd = 0;
    end else if (size == 1) exp_wd = (wd & 32'hFF) * 32'h0101_0101;
    else if (size == 2) exp_wd = (wd & 32'hFFFF) * 32'h0001_0001;
    else exp_wd = wd;
    exp_lat = we ? 2 + gd : 3 + gd + rd;
    t_done = -1;

    @(negedge clk);
    req_c = 1; we_c = we; funct3_c = f3;
    addr_i = a; wdata_i = wd;
    mem_gnt_i = 0;
    mem_rvalid_i = 1'($urandom % 2);
    mem_rdata_i = $urandom;
    #1;
    chk("idle_done", done_o, 0);
    chk("err", err_o, 32'(!ok));
    chk("stall_c0", stall_o, 32'(ok));
    chk("req_c0", mem_req_o, 0);
    if (!ok) begin
      @(negedge clk);
      req_c = 0; mem_rvalid_i = 0;
      #1;
      chk("err_noreq", mem_req_o, 0);
      chk("err_stall", stall_o, 0);
      chk("err_rdata", rdata_o, m_rdata);
      return;
    end

    lat = -1; nreq = 0; waitc = 0; granted = 0;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge clk);
      mem_gnt_i = 0; mem_rvalid_i = 0;
      if (done_o) begin
        lat = c;
        t_done = cyc;
      end else begin
        chk("stall", stall_o, 1);
        if (mem_req_o) begin
          chk("addr", mem_addr_o, a & ~32'h3);
          chk("we", mem_we_o, 32'(we));
          chk("be", mem_be_o, exp_be);
          chk("wdata", mem_wdata_o, exp_wd);
          if (nreq == gd) begin
            mem_gnt_i = 1;
            granted = 1;
          end
          nreq++;
        end else if (granted && !we) begin
          if (waitc == rd) begin
            mem_rdata_i = word;
            mem_rvalid_i = 1;
          end else mem_rdata_i = $urandom;
          waitc++;
        end
      end
    end
    chk("latency", lat, exp_lat);
    chk("nreq", nreq, gd + 1);
    chk("resp_stall", stall_o, 0);
    chk("resp_req", mem_req_o, 0);
    if (!we) m_rdata = val;
    chk("rdata", rdata_o, m_rdata);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_c = 0;
      mem_rvalid_i = 1'($urandom % 2);
      mem_rdata_i = $urandom;
      #1;
      chk("idle_done", done_o, 0);
      chk("idle_stall", stall_o, 0);
      chk("idle_rdata", rdata_o, m_rdata);
    end
    mem_rvalid_i = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2;
    req_c = 1;
    #2;
    chk("rst_stall", stall_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_req", mem_req_o, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_be", mem_be_o, 0);
    req_c = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;

    do_op(0, 3'b000, 32'h1003, 0, 0, 0, 32'h80FF_1234, t1);
    chk("lb_val", rdata_o, 32'hFFFF_FF80);
    do_op(0, 3'b100, 32'h1003, 0, 0, 0, 32'h80FF_1234, t1);
    chk("lbu_val", rdata_o, 32'h0000_0080);
    idle(1);

    do_op(1, 3'b001, 32'h2002, 32'hABCD_5678, 3, 0, 0, t1);
    idle(1);

    do_op(0, 3'b010, 32'h0006, 0, 0, 0, 32'hDEAD_BEEF, t1);
    idle(4);

    do_op(0, 3'b001, 32'h0002, 0, 0, 5, 32'h8001_7FFF, t1);
    chk("lh_val", rdata_o, 32'hFFFF_8001);
    idle(1);

    // reset while waiting for read data
    @(negedge clk);
    req_c = 1; we_c = 0; funct3_c = 3'b001; addr_i = 0;
    @(negedge clk);
    chk("r_req", mem_req_o, 1);
    mem_gnt_i = 1;
    @(negedge clk);
    mem_gnt_i = 0;
    chk("r_wait_stall", stall_o, 1);
    #2 rst_n = 0;
    #1;
    m_rdata = 0;
    chk("r_req_lo", mem_req_o, 0);
    chk("r_stall_lo", stall_o, 0);
    chk("r_done_lo", done_o, 0);
    chk("r_err_lo", err_o, 0);
    chk("r_rdata", rdata_o, 0);
    chk("r_addr", mem_addr_o, 0);
    @(negedge clk);
    rst_n = 1; req_c = 0;
    @(negedge clk);
    mem_rvalid_i = 1;
    mem_rdata_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_rvalid_i = 0;
      chk("r_late_done", done_o, 0);
      chk("r_late_stall", stall_o, 0);
    end
    do_op(1, 3'b000, 32'h10, 32'h0000_005A, 0, 0, 0, t1);
    idle(1);

    do_op(1, 3'b010, 32'h40, 32'h1234_5678, 0, 0, 0, t1);
    do_op(0, 3'b010, 32'h40, 0, 0, 0, 32'h1234_5678, t2);
    chk("b2b_gap", t2 - t1, 4);
    idle(1);

    for (int i = 0; i < 60; i++) begin
      do_op(1'($urandom % 2), 3'($urandom % 8),
            $urandom, $urandom,
            int'($urandom % 4), int'($urandom % 4),
            $urandom, t1);
      if ($urandom % 3 == 0) idle(1);
    end
    idle(1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
